decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised decode stage that sits between fetch and execute. It decodes the full RV32I integer ALU, upper-immediate and load/store subset into `instr_data_t` when an instruction is accepted. Decoded entries are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides. Flush support lets branch/redirect logic drop in-flight instructions.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `clk_i`  in  1: clock, rising edge.
- `rst_i`  in  1: asynchronous, active-high reset.
- `flush_i`  in  1: drop all buffered entries.
- `valid_i`  in  1: fetch offers an instruction.
- `ready_o`  out  1: queue can accept.
- `pc_i`  in  `bus32_t`: PC of offered instruction.
- `instr_i`  in  `instruction_t`: raw instruction.
- `valid_o`  out  1: head entry is valid.
- `ready_i`  in  1: execute consumes the head entry.
- `instr_decoded_o`  out  `instr_data_t`: decoded head entry.
- `count_o`  out  `$clog2(DEPTH)+1`: occupancy.
- `illegal_o`  out  1: head entry is illegal. Present only with `DECODE_ILLEGAL_FLAG_EN`.

## Operation

- **Push:** `valid_i && ready_o && !flush_i`. The decoded struct is written at `wr_ptr`.
- **Pop:** `valid_o && ready_i && !flush_i`. `rd_ptr` advances.
- **Status:** `ready_o = (count < DEPTH)`; `valid_o = (count != 0)`. There is no bypass: a full queue does not accept even when popping in the same cycle.
- **Simultaneous push and pop:** count unchanged, both pointers advance.
- **Pointer wrap:** pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH.
- **Flush:** both pointers and count go to 0 at the next edge. Any push or pop in the flush cycle is ignored.
- **Output stability:** `instr_decoded_o` is driven from storage and must hold stable while `valid_o && !ready_i`.
- **Pass-through fields:** `pc` and `instr` are copied unchanged. `addr_rs1`, `addr_rs2` and `addr_rd` come from instruction bits [19:15], [24:20] and [11:7] unless overridden below.
- **Decode rules:**
  - OP_ALU_I: we=1, RS1, IMM, ALU.
    - ADDI→ADD, SLTI→SLT, SLTIU→SLTU, XORI→XOR, ORI→OR, ANDI→AND.
    - SLLI requires func7=0x00.
    - SRLI (func7 0x00) / SRAI (func7 0x20).
  - OP_ALU: we=1, RS1, RS2, ALU.
    - func7 0x00 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
    - func7 0x20 selects SUB or SRA only.
  - OP_LUI: we=1, RS1 with `addr_rs1=0`, IMM, ADD, ALU.
  - OP_AUIPC: we=1, PC, IMM, ADD, ALU.
  - OP_LOAD: we=1, RS1, IMM, ADD, MEM, mem_we=0.
  - OP_STORE: we=0, `addr_rd=0`, RS1, IMM, ADD, MEM, mem_we=1.
- **Illegal encodings:** any unlisted opcode, func3 or func7 decodes as a NOP: we=0, mem_we=0, RS1/RS2, all register addresses 0, ADD, ALU.

## Timing

- Reset values:
  - Pointers, count and storage are cleared to 0.
  - `valid_o`=0, `count_o`=0, `instr_decoded_o`='0, `illegal_o`=0.
  - `ready_o`=1.
- Pushes while `rst_i` is high are ignored. Deasserting reset mid-stream leaves the queue empty.
- Latency from push edge to `valid_o` is 1 cycle. Throughput is 1 instruction per cycle.
- `ready_o` and `valid_o` depend only on registered state, never combinationally on `valid_i` or `ready_i`.

## Configuration

- `DECODE_ILLEGAL_FLAG_EN`:
  - Defined: each entry stores an illegal bit, and `illegal_o` reflects the head entry (0 when empty).
  - Undefined: no port and no storage bit; illegal instructions are indistinguishable from NOPs.

## Structure

- `riscv_pkg` gains:
  - `OP_AUIPC`, `OP_LOAD`, `OP_STORE`.
  - All F3_* values and `F7_BASE`=0x00 / `F7_ALT`=0x20.
- `tartaruga_pkg` gains:
  - `alu_op_t` values SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - `mem_we` field in `instr_data_t`.
  - `PC` already exists as an operand-select value.
- Sub-module `decoder_rv32i`: purely combinational, implements the decode rules above and the illegal flag. It is instantiated on the write side of the FIFO.

## Test plan

- **ADDI:** push 0x00500093 (addi x1,x0,5) at pc 0x100.
  - Next cycle: `valid_o`=1, rd=1, rs1=0, IMM, ADD, we=1, pc=0x100.
- **SUB/SRA:** push 0x402081B3 (sub x3,x1,x2) then 0x4020D1B3 (sra x3,x1,x2).
  - Head shows SUB, then SRA; RS2, we=1.
- **Fill and drain:** DEPTH=4, `ready_i`=0, five pushes.
  - After four: `ready_o`=0, `count_o`=4; the fifth is not accepted.
  - Then `ready_i`=1: entries drain in order, one per cycle.
  - Push and pop together at count=2: count stays 2 and pointers wrap correctly.
- **Flush:** flush with 3 entries while `valid_i`=1.
  - Next cycle: `count_o`=0, `valid_o`=0; the concurrent instruction is dropped.
- **Illegal:** push 0xFFFFFFFF.
  - Head: we=0, all register addresses 0, ADD.
  - `illegal_o`=1 with the macro; port absent without it.
- **Reset mid-operation:** assert `rst_i` mid-stream with 2 entries.
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - After release, the first push appears after 1 cycle.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// RV32I encodings and decoded-entry types shared by decode_queue and decoder_rv32i.
package decode_queue_pkg;

   typedef logic [31:0] bus32_t;
   typedef logic [31:0] instruction_t;

   localparam logic [6:0] OP_ALU_I = 7'b0010011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;

   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   typedef enum logic [3:0] {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND} alu_op_t;
   typedef enum logic {RS1, PC}  op_a_sel_t;
   typedef enum logic {RS2, IMM} op_b_sel_t;
   typedef enum logic {ALU, MEM} res_sel_t;

   typedef struct packed {
      bus32_t       pc;
      instruction_t instr;
      logic [4:0]   addr_rs1;
      logic [4:0]   addr_rs2;
      logic [4:0]   addr_rd;
      logic         we;
      op_a_sel_t    op_a_sel;
      op_b_sel_t    op_b_sel;
      alu_op_t      alu_op;
      res_sel_t     res_sel;
      logic         mem_we;
   } instr_data_t;

   // Base (func7 0x00) mapping; shifts right default to logical.
   function automatic alu_op_t f3_to_alu(input logic [2:0] f3);
      case (f3)
         F3_ADD:  return ADD;
         F3_SLL:  return SLL;
         F3_SLT:  return SLT;
         F3_SLTU: return SLTU;
         F3_XOR:  return XOR;
         F3_SR:   return SRL;
         F3_OR:   return OR;
         default: return AND;
      endcase
   endfunction

endpackage

// File: rtl/decode_queue_decoder.sv
// Combinational RV32I ALU/upper-immediate/load-store decoder; illegal encodings become NOPs.
// o_illegal exists only when DECODE_ILLEGAL_FLAG_EN is defined.
module decoder_rv32i
   import decode_queue_pkg::*;
(
   input  bus32_t       i_pc,
   input  instruction_t i_instr,
`ifdef DECODE_ILLEGAL_FLAG_EN
   output logic         o_illegal,
`endif
   output instr_data_t  o_decoded
);

   logic [6:0] w_opcode;
   logic [2:0] w_f3;
   logic [6:0] w_f7;
   logic       w_illegal;

   assign w_opcode = i_instr[6:0];
   assign w_f3     = i_instr[14:12];
   assign w_f7     = i_instr[31:25];

   always_comb begin
      o_decoded          = '0;
      o_decoded.pc       = i_pc;
      o_decoded.instr    = i_instr;
      o_decoded.addr_rs1 = i_instr[19:15];
      o_decoded.addr_rs2 = i_instr[24:20];
      o_decoded.addr_rd  = i_instr[11:7];
      w_illegal          = 1'b0;

      case (w_opcode)
         OP_ALU_I: begin
            o_decoded.we       = 1'b1;
            o_decoded.op_b_sel = IMM;
            case (w_f3)
               F3_SLL: begin
                  o_decoded.alu_op = SLL;
                  w_illegal        = (w_f7 != F7_BASE);
               end
               F3_SR: begin
                  if (w_f7 == F7_BASE)     o_decoded.alu_op = SRL;
                  else if (w_f7 == F7_ALT) o_decoded.alu_op = SRA;
                  else                     w_illegal = 1'b1;
               end
               default: o_decoded.alu_op = f3_to_alu(w_f3);
            endcase
         end
         OP_ALU: begin
            o_decoded.we = 1'b1;
            if (w_f7 == F7_BASE) begin
               o_decoded.alu_op = f3_to_alu(w_f3);
            end else if (w_f7 == F7_ALT) begin
               case (w_f3)
                  F3_ADD:  o_decoded.alu_op = SUB;
                  F3_SR:   o_decoded.alu_op = SRA;
                  default: w_illegal = 1'b1;
               endcase
            end else begin
               w_illegal = 1'b1;
            end
         end
         OP_LUI: begin
            o_decoded.we       = 1'b1;
            o_decoded.addr_rs1 = 5'd0;
            o_decoded.op_b_sel = IMM;
         end
         OP_AUIPC: begin
            o_decoded.we       = 1'b1;
            o_decoded.op_a_sel = PC;
            o_decoded.op_b_sel = IMM;
         end
         OP_LOAD: begin
            o_decoded.we       = 1'b1;
            o_decoded.op_b_sel = IMM;
            o_decoded.res_sel  = MEM;
            case (w_f3)
               F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ;
               default: w_illegal = 1'b1;
            endcase
         end
         OP_STORE: begin
            o_decoded.addr_rd  = 5'd0;
            o_decoded.op_b_sel = IMM;
            o_decoded.res_sel  = MEM;
            o_decoded.mem_we   = 1'b1;
            w_illegal = (w_f3 != F3_SB) && (w_f3 != F3_SH) && (w_f3 != F3_SW);
         end
         default: w_illegal = 1'b1;
      endcase

      // Illegal encodings collapse to a harmless NOP, keeping pc/instr for debug.
      if (w_illegal) begin
         o_decoded.we       = 1'b0;
         o_decoded.mem_we   = 1'b0;
         o_decoded.addr_rs1 = 5'd0;
         o_decoded.addr_rs2 = 5'd0;
         o_decoded.addr_rd  = 5'd0;
         o_decoded.op_a_sel = RS1;
         o_decoded.op_b_sel = RS2;
         o_decoded.alu_op   = ADD;
         o_decoded.res_sel  = ALU;
      end
   end

`ifdef DECODE_ILLEGAL_FLAG_EN
   assign o_illegal = w_illegal;
`endif

endmodule

// File: rtl/decode_queue.sv
// Decode stage: decodes on push and buffers entries in a DEPTH-deep FIFO with flush.
// Optional per-entry illegal flag and illegal_o port under DECODE_ILLEGAL_FLAG_EN.
module decode_queue
   import decode_queue_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  bus32_t                 pc_i,
   input  instruction_t           instr_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output instr_data_t            instr_decoded_o,
`ifdef DECODE_ILLEGAL_FLAG_EN
   output logic                   illegal_o,
`endif
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   instr_data_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   instr_data_t      w_decoded;
   logic             w_push;
   logic             w_pop;

`ifdef DECODE_ILLEGAL_FLAG_EN
   logic             r_illegal [DEPTH];
   logic             w_illegal;
`endif

   decoder_rv32i u_decoder (
      .i_pc      (pc_i),
      .i_instr   (instr_i),
`ifdef DECODE_ILLEGAL_FLAG_EN
      .o_illegal (w_illegal),
`endif
      .o_decoded (w_decoded)
   );

   // Status comes from registered state only; no full-queue bypass.
   assign ready_o = (r_count < CNT_W'(DEPTH));
   assign valid_o = (r_count != '0);
   assign w_push  = valid_i && ready_o && !flush_i;
   assign w_pop   = valid_o && ready_i && !flush_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
`ifdef DECODE_ILLEGAL_FLAG_EN
            r_illegal[i] <= 1'b0;
`endif
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= w_decoded;
`ifdef DECODE_ILLEGAL_FLAG_EN
         r_illegal[r_wr_ptr] <= w_illegal;
`endif
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign instr_decoded_o = r_mem[r_rd_ptr];
   assign count_o         = r_count;

`ifdef DECODE_ILLEGAL_FLAG_EN
   assign illegal_o = valid_o && r_illegal[r_rd_ptr];
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: expected entries queued on push, compared at the head.
// Checks illegal_o as well when DECODE_ILLEGAL_FLAG_EN is defined.
module tb_decode_queue;
   import decode_queue_pkg::*;

   localparam int DEPTH = 4;

   localparam instruction_t I_ADDI  = 32'h00500093;
   localparam instruction_t I_SUB   = 32'h402081B3;
   localparam instruction_t I_SRA   = 32'h4020D1B3;
   localparam instruction_t I_LUI   = 32'h123452B7;
   localparam instruction_t I_AUIPC = 32'h00001317;
   localparam instruction_t I_LW    = 32'h00812383;
   localparam instruction_t I_SW    = 32'h00512623;
   localparam instruction_t I_SLLIB = 32'h02009093;
   localparam instruction_t I_ILL   = 32'hFFFFFFFF;

   typedef struct {
      instr_data_t d;
      logic        ill;
   } exp_t;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   flush_i;
   logic                   valid_i;
   logic                   ready_o;
   bus32_t                 pc_i;
   instruction_t           instr_i;
   logic                   valid_o;
   logic                   ready_i;
   instr_data_t            instr_decoded_o;
   logic [$clog2(DEPTH):0] count_o;
`ifdef DECODE_ILLEGAL_FLAG_EN
   logic                   illegal_o;
`endif

   exp_t sbq[$];
   exp_t e_idle;
   int   total = 0;
   int   bad   = 0;

   decode_queue #(.DEPTH(DEPTH)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .flush_i         (flush_i),
      .valid_i         (valid_i),
      .ready_o         (ready_o),
      .pc_i            (pc_i),
      .instr_i         (instr_i),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .instr_decoded_o (instr_decoded_o),
`ifdef DECODE_ILLEGAL_FLAG_EN
      .illegal_o       (illegal_o),
`endif
      .count_o         (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input bus32_t pc, input instruction_t ins,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic we, input op_a_sel_t a, input op_b_sel_t b,
                               input alu_op_t op, input res_sel_t r, input logic mw, input logic ill);
      exp_t e;
      e.d.pc       = pc;
      e.d.instr    = ins;
      e.d.addr_rs1 = rs1;
      e.d.addr_rs2 = rs2;
      e.d.addr_rd  = rd;
      e.d.we       = we;
      e.d.op_a_sel = a;
      e.d.op_b_sel = b;
      e.d.alu_op   = op;
      e.d.res_sel  = r;
      e.d.mem_we   = mw;
      e.ill        = ill;
      return e;
   endfunction

   function automatic exp_t mk_nop(input bus32_t pc, input instruction_t ins);
      return mk(pc, ins, 5'd0, 5'd0, 5'd0, 1'b0, RS1, RS2, ADD, ALU, 1'b0, 1'b1);
   endfunction

   // One clock cycle: drive inputs, check status/head against the model, update the model.
   task automatic step(input logic v, input bus32_t pc, input instruction_t ins, input exp_t e,
                       input logic rdy, input logic fl);
      int sz;
      sz      = sbq.size();
      valid_i = v;
      pc_i    = pc;
      instr_i = ins;
      ready_i = rdy;
      flush_i = fl;
      #1;
      check("count", 128'(count_o), 128'(sz));
      check("valid", 128'(valid_o), 128'(sz != 0));
      check("ready", 128'(ready_o), 128'(sz < DEPTH));
      if (sz != 0) begin
         check("head", 128'(instr_decoded_o), 128'(sbq[0].d));
`ifdef DECODE_ILLEGAL_FLAG_EN
         check("illegal", 128'(illegal_o), 128'(sbq[0].ill));
`endif
      end else begin
`ifdef DECODE_ILLEGAL_FLAG_EN
         check("illegal_empty", 128'(illegal_o), 128'(0));
`endif
      end
      if (fl) begin
         $display("flush dropped=%0d", sz);
         sbq.delete();
      end else begin
         if (sz != 0 && rdy) begin
            $display("pop  pc=%h instr=%h", sbq[0].d.pc, sbq[0].d.instr);
            void'(sbq.pop_front());
         end
         if (v && sz < DEPTH) begin
            $display("push pc=%h instr=%h", pc, ins);
            sbq.push_back(e);
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_count"}, 128'(count_o), 128'(0));
      check({tag, "_valid"}, 128'(valid_o), 128'(0));
      check({tag, "_ready"}, 128'(ready_o), 128'(1));
      check({tag, "_data"},  128'(instr_decoded_o), 128'(0));
`ifdef DECODE_ILLEGAL_FLAG_EN
      check({tag, "_illegal"}, 128'(illegal_o), 128'(0));
`endif
   endtask

   initial begin
      e_idle  = mk(32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, RS1, RS2, ADD, ALU, 1'b0, 1'b0);
      rst_i   = 1'b1;
      flush_i = 1'b0;
      valid_i = 1'b1;
      ready_i = 1'b0;
      pc_i    = 32'h100;
      instr_i = I_ADDI;
      repeat (2) @(posedge clk_i);
      #1;
      check_reset_outputs("reset");
      rst_i = 1'b0;

      // ADDI then consume
      step(1, 32'h100, I_ADDI, mk(32'h100, I_ADDI, 5'd0, 5'd5, 5'd1, 1, RS1, IMM, ADD, ALU, 0, 0), 0, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);

      // SUB then SRA
      step(1, 32'h104, I_SUB, mk(32'h104, I_SUB, 5'd1, 5'd2, 5'd3, 1, RS1, RS2, SUB, ALU, 0, 0), 0, 0);
      step(1, 32'h108, I_SRA, mk(32'h108, I_SRA, 5'd1, 5'd2, 5'd3, 1, RS1, RS2, SRA, ALU, 0, 0), 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 0, 0);

      // Fill to full; fifth push must be refused
      step(1, 32'h200, I_LUI,   mk(32'h200, I_LUI,   5'd0, 5'd3, 5'd5, 1, RS1, IMM, ADD, ALU, 0, 0), 0, 0);
      step(1, 32'h204, I_AUIPC, mk(32'h204, I_AUIPC, 5'd0, 5'd0, 5'd6, 1, PC,  IMM, ADD, ALU, 0, 0), 0, 0);
      step(1, 32'h208, I_LW,    mk(32'h208, I_LW,    5'd2, 5'd8, 5'd7, 1, RS1, IMM, ADD, MEM, 0, 0), 0, 0);
      step(1, 32'h20C, I_SW,    mk(32'h20C, I_SW,    5'd2, 5'd5, 5'd0, 0, RS1, IMM, ADD, MEM, 1, 0), 0, 0);
      step(1, 32'h210, I_SLLIB, mk_nop(32'h210, I_SLLIB), 0, 0);
      check("full_count", 128'(count_o), 128'(4));
      check("full_ready", 128'(ready_o), 128'(0));

      // Drain two, then push+pop at count 2 across the pointer wrap
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(1, 32'h214, I_ILL,   mk_nop(32'h214, I_ILL), 1, 0);
      step(1, 32'h218, I_SLLIB, mk_nop(32'h218, I_SLLIB), 1, 0);
      check("pushpop_count", 128'(count_o), 128'(2));
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 0, 0);

      // Flush with three entries and a concurrent push/pop
      for (int i = 0; i < 3; i++) begin
         step(1, 32'h400 + 32'(4 * i), I_ADDI,
              mk(32'h400 + 32'(4 * i), I_ADDI, 5'd0, 5'd5, 5'd1, 1, RS1, IMM, ADD, ALU, 0, 0), 0, 0);
      end
      step(1, 32'h40C, I_SUB, e_idle, 1, 1);
      step(0, 32'h0, 32'h0, e_idle, 0, 0);

      // Illegal encoding
      step(1, 32'h500, I_ILL, mk_nop(32'h500, I_ILL), 0, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 0, 0);

      // Asynchronous reset with two entries in flight
      step(1, 32'h600, I_SUB, mk(32'h600, I_SUB, 5'd1, 5'd2, 5'd3, 1, RS1, RS2, SUB, ALU, 0, 0), 0, 0);
      step(1, 32'h604, I_SRA, mk(32'h604, I_SRA, 5'd1, 5'd2, 5'd3, 1, RS1, RS2, SRA, ALU, 0, 0), 0, 0);
      check("pre_reset_count", 128'(count_o), 128'(2));
      valid_i = 1'b1;
      pc_i    = 32'h608;
      instr_i = I_ADDI;
      rst_i   = 1'b1;
      #2;
      check_reset_outputs("async_reset");
      sbq.delete();
      @(posedge clk_i);
      #1;
      check("reset_push_ignored", 128'(count_o), 128'(0));
      rst_i = 1'b0;
      step(1, 32'h700, I_ADDI, mk(32'h700, I_ADDI, 5'd0, 5'd5, 5'd1, 1, RS1, IMM, ADD, ALU, 0, 0), 0, 0);
      step(0, 32'h0, 32'h0, e_idle, 1, 0);
      step(0, 32'h0, 32'h0, e_idle, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
